// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the triangle-channel note sequencer: song ROM word
// layout, sequencer state encoding and the silent channel-register value.
package apu_pkg;

  localparam int TIMER_LSB  = 0;
  localparam int TIMER_MSB  = 10;
  localparam int RELOAD_LSB = 11;
  localparam int RELOAD_MSB = 17;
  localparam int LENGTH_LSB = 18;
  localparam int LENGTH_MSB = 22;
  localparam int DUR_LSB    = 23;
  localparam int DUR_MSB    = 30;
  localparam int END_BIT    = 31;

  localparam logic [7:0] SILENT_REG1 = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_LOAD  = 3'd3,
    S_PLAY  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } seq_state_t;

  // A zero timer marks a rest: the linear counter is never reloaded.
  function automatic logic [6:0] effective_reload(input logic [10:0] timer,
                                                  input logic [6:0]  reload);
    logic [6:0] result;
    if (timer == 11'd0) begin
      result = 7'd0;
    end else begin
      result = reload;
    end
    return result;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control, song-ROM and channel-register signals between a host and the
// note sequencer.
interface note_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              stop;
  logic              loop;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic [7:0]        reg1;
  logic [7:0]        reg2;
  logic [7:0]        reg3;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, loop, rom_data,
    input  rom_addr, reg1, reg2, reg3, busy, done
  );

  modport slave (
    input  start, stop, loop, rom_data,
    output rom_addr, reg1, reg2, reg3, busy, done
  );
endinterface

// File: rtl/note_sequencer_rise_detect.sv
// One-clock pulse on each rising edge of a slow strobe (clk240, clk120, ...)
// that is synchronous to i_clk.
module rise_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_pulse
);
  logic r_sig_q;

  // Previous-cycle copy of the strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sig_q <= 1'b0;
    end else begin
      r_sig_q <= i_sig;
    end
  end

  assign o_pulse = i_sig & ~r_sig_q;
endmodule

// File: rtl/note_sequencer.sv
// Steps through a song ROM and drives the three triangle-channel register
// values, holding each note for a programmed number of quarter-frame ticks.
module note_sequencer
  import apu_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk240,
  note_sequencer_if.slave bus
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  seq_state_t        r_state;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [7:0]        r_reg1;
  logic [7:0]        r_reg2;
  logic [7:0]        r_reg3;
  logic              r_busy;
  logic              r_done;
  logic [7:0]        r_tick_cnt;
  logic [3:0]        r_hold_cnt;
  logic [7:0]        r_duration;
  logic              r_end_flag;

  logic              w_tick;
  logic [10:0]       w_timer;
  logic [6:0]        w_reload;
  logic [4:0]        w_length;
  logic [7:0]        w_duration;
  logic              w_end_flag;

  rise_detect u_tick (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_sig   (clk240),
    .o_pulse (w_tick)
  );

  assign w_timer    = bus.rom_data[TIMER_MSB:TIMER_LSB];
  assign w_reload   = effective_reload(w_timer, bus.rom_data[RELOAD_MSB:RELOAD_LSB]);
  assign w_length   = bus.rom_data[LENGTH_MSB:LENGTH_LSB];
  assign w_duration = bus.rom_data[DUR_MSB:DUR_LSB];
  assign w_end_flag = bus.rom_data[END_BIT];

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_rom_addr <= '0;
      r_reg1     <= SILENT_REG1;
      r_reg2     <= 8'h00;
      r_reg3     <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tick_cnt <= 8'd0;
      r_hold_cnt <= 4'd0;
      r_duration <= 8'd0;
      r_end_flag <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.stop && r_busy) begin
        // Abort: silence the channel but leave the timer registers alone.
        r_state    <= S_IDLE;
        r_reg1     <= SILENT_REG1;
        r_rom_addr <= '0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start && !bus.stop) begin
              r_rom_addr <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
          S_FETCH: begin
            r_state <= S_LATCH;
          end
          S_LATCH: begin
            r_duration <= w_duration;
            r_end_flag <= w_end_flag;
            r_reg1     <= {1'b1, w_reload};
            r_reg2     <= w_timer[7:0];
            r_reg3     <= {w_length, w_timer[10:8]};
            r_hold_cnt <= HOLD_LOAD;
            r_state    <= S_LOAD;
          end
          S_LOAD: begin
            if (r_hold_cnt == 4'd0) begin
              r_reg1[7]  <= 1'b0;
              r_tick_cnt <= r_duration;
              r_state    <= S_PLAY;
            end else begin
              r_hold_cnt <= r_hold_cnt - 4'd1;
            end
          end
          S_PLAY: begin
            if (r_tick_cnt == 8'd0) begin
              r_state <= S_NEXT;
            end else if (w_tick) begin
              r_tick_cnt <= r_tick_cnt - 8'd1;
            end
          end
          S_NEXT: begin
            if (r_end_flag) begin
              if (bus.loop) begin
                r_rom_addr <= '0;
                r_state    <= S_FETCH;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end
            end else if (&r_rom_addr) begin
              // Last table slot without an end flag: finish, never wrap.
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_rom_addr <= r_rom_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
              r_state    <= S_FETCH;
            end
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_reg1  <= SILENT_REG1;
            r_state <= S_IDLE;
          end
          default: begin
            r_reg1  <= SILENT_REG1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rom_addr = r_rom_addr;
  assign bus.reg1     = r_reg1;
  assign bus.reg2     = r_reg2;
  assign bus.reg3     = r_reg3;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed songs from the test plan
// plus random tables, checked against a note-level model of the song walk.
module tb_note_sequencer;

  localparam int ADDR_W = 8;
  localparam int LIMIT  = 20000;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic clk240 = 1'b0;

  note_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  note_sequencer #(.ADDR_W(ADDR_W), .HOLD_CYCLES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk240 (clk240),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [0:255];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle count and the tick the DUT sees at each rising clock edge.
  int cyc       = 0;
  bit last_tick = 1'b0;
  bit p240      = 1'b0;
  always @(posedge clk) begin
    cyc++;
    last_tick = clk240 & ~p240;
    p240      = clk240;
  end

  // Quarter-frame strobe: random half periods, or a manual level.
  bit gen_en = 1'b0;
  bit man240 = 1'b0;
  int half   = 2;
  always @(posedge clk) begin
    #2;
    if (gen_en) begin
      if (half <= 1) begin
        clk240 = ~clk240;
        half   = $urandom_range(2, 4);
      end else begin
        half--;
      end
    end else begin
      clk240 = man240;
    end
  end

  typedef struct {
    int          addr;
    logic [31:0] w;
  } note_t;

  note_t       exp_q[$];
  bit          mon_en    = 1'b0;
  bit          playing   = 1'b0;
  int          exit_edge = -1;
  int          remaining = 0;
  int          done_cnt  = 0;
  logic [7:0]  prev_reg1 = 8'h80;
  note_t       m_n;
  int          m_timer, m_reload, m_len, m_dur, m_eff;

  // Note-level model: a note enters play when control drops; it must leave
  // play one clock after its duration-th tick counted after entry.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (!mon_en || !reset) begin
      playing = 1'b0;
    end else if (prev_reg1[7] && !bus.reg1[7] && bus.busy) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_note", exp_q.size(), 1);
      end else begin
        m_n      = exp_q.pop_front();
        m_timer  = int'(m_n.w % 2048);
        m_reload = int'((m_n.w / 2048) % 128);
        m_len    = int'((m_n.w / 262144) % 32);
        m_dur    = int'((m_n.w / 8388608) % 256);
        m_eff    = (m_timer == 0) ? 0 : m_reload;
        check_eq("note_addr", bus.rom_addr, m_n.addr);
        check_eq("load_reg1", prev_reg1, 128 + m_eff);
        check_eq("note_reg2", bus.reg2, m_timer % 256);
        check_eq("note_reg3", bus.reg3, m_len * 8 + m_timer / 256);
        check_eq("play_reg1", bus.reg1, m_eff);
        playing   = 1'b1;
        remaining = m_dur;
        exit_edge = (m_dur == 0) ? cyc + 1 : -1;
      end
    end else if (playing && !prev_reg1[7] && bus.reg1[7]) begin
      check_eq("note_length", (bus.done === 1'b1) ? cyc - 2 : cyc - 3, exit_edge);
      playing = 1'b0;
    end else if (playing && exit_edge < 0 && last_tick) begin
      remaining--;
      if (remaining == 0) exit_edge = cyc + 1;
    end
    prev_reg1 = bus.reg1;
  end

  task automatic pulse_ctl(input bit s, input bit p);
    @(negedge clk);
    bus.start = s;
    bus.stop  = p;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  // Walk the table by the song rules and queue the notes expected to play.
  task automatic build_expect(input bit lp, input int max_notes, output bit ends);
    int a;
    a    = 0;
    ends = 1'b0;
    for (int k = 0; k < max_notes; k++) begin
      exp_q.push_back('{a, rom[a]});
      if (rom[a][31]) begin
        if (lp) a = 0;
        else begin ends = 1'b1; break; end
      end else if (a == 255) begin
        ends = 1'b1;
        break;
      end else begin
        a++;
      end
    end
  endtask

  task automatic run_song(input string tag, input bit lp, input int max_notes, input bit poke);
    bit ends;
    int base;
    int t;
    exp_q.delete();
    build_expect(lp, max_notes, ends);
    bus.loop = lp;
    base     = done_cnt;
    mon_en   = 1'b1;
    pulse_ctl(1'b1, 1'b0);
    t = 0;
    while (t < LIMIT && (ends ? (done_cnt == base) : (exp_q.size() != 0))) begin
      @(negedge clk);
      bus.start = poke && (t == 8);
      t++;
    end
    bus.start = 1'b0;
    check_eq({tag, "_timeout"}, t < LIMIT, 1);
    check_eq({tag, "_left"}, exp_q.size(), 0);
    if (ends) begin
      repeat (3) @(negedge clk);
      check_eq({tag, "_done"}, done_cnt - base, 1);
      check_eq({tag, "_busy"}, bus.busy, 0);
      check_eq({tag, "_reg1"}, bus.reg1, 8'h80);
    end else begin
      check_eq({tag, "_nodone"}, done_cnt - base, 0);
    end
  endtask

  function automatic logic [31:0] entry(input bit e, input int dur, input int len,
                                        input int rel, input int tmr);
    logic [31:0] w;
    w = {e, 8'(dur), 5'(len), 7'(rel), 11'(tmr)};
    return w;
  endfunction

  function automatic logic [31:0] rand_entry(input bit e, input int dmax);
    int tmr;
    tmr = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2047));
    return entry(e, $urandom_range(0, dmax), $urandom_range(0, 31), $urandom_range(0, 127), tmr);
  endfunction

  int changes;
  int wait_t;
  int base_d;

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.loop  = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;

    // Reset held with the strobe running.
    gen_en = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("rst_reg1", bus.reg1, 8'h80);
    check_eq("rst_reg2", bus.reg2, 8'h00);
    check_eq("rst_reg3", bus.reg3, 8'h00);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_addr", bus.rom_addr, 0);
    reset   = 1'b1;
    changes = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.reg1 !== 8'h80 || bus.reg2 !== 8'h00 || bus.reg3 !== 8'h00 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rom_addr !== 8'd0) changes++;
    end
    check_eq("idle_quiet", changes, 0);

    // Single note, manual ticks.
    gen_en = 1'b0;
    man240 = 1'b0;
    rom[0] = entry(1'b1, 3, 8, 50, 1358);
    repeat (4) @(negedge clk);
    base_d = done_cnt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("c3_reg1", bus.reg1, 8'hB2);
    check_eq("c3_reg2", bus.reg2, 8'h4E);
    check_eq("c3_reg3", bus.reg3, 8'h45);
    @(negedge clk);
    check_eq("c4_reg1", bus.reg1, 8'hB2);
    @(negedge clk);
    check_eq("c5_reg1", bus.reg1, 8'h32);
    for (int k = 0; k < 2; k++) begin
      man240 = 1'b1;
      repeat (3) @(negedge clk);
      man240 = 1'b0;
      repeat (3) @(negedge clk);
    end
    check_eq("two_ticks_nodone", done_cnt - base_d, 0);
    check_eq("two_ticks_busy", bus.busy, 1);
    man240 = 1'b1;
    wait_t = 0;
    while (wait_t < 20 && done_cnt == base_d) begin
      @(negedge clk);
      wait_t++;
    end
    man240 = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("one_note_done", done_cnt - base_d, 1);
    check_eq("one_note_reg1", bus.reg1, 8'h80);
    check_eq("one_note_busy", bus.busy, 0);

    // Three-note melody, with and without looping.
    gen_en = 1'b1;
    rom[0] = entry(1'b0, 2, 8, 50, 1358);
    rom[1] = entry(1'b0, 2, 8, 50, 1524);
    rom[2] = entry(1'b1, 2, 8, 50, 1712);
    run_song("melody", 1'b0, 10, 1'b0);
    run_song("loop", 1'b1, 4, 1'b0);
    mon_en = 1'b0;
    pulse_ctl(1'b0, 1'b1);
    check_eq("stop_reg1", bus.reg1, 8'h80);
    check_eq("stop_busy", bus.busy, 0);
    check_eq("stop_addr", bus.rom_addr, 0);
    check_eq("stop_reg2", bus.reg2, 8'h4E);
    bus.loop = 1'b0;
    repeat (5) @(negedge clk);

    // start together with stop while idle: stop wins.
    pulse_ctl(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("start_stop_idle", bus.busy, 0);

    // Rest note and zero-duration note.
    rom[0] = entry(1'b0, 1, 3, 50, 0);
    rom[1] = entry(1'b0, 0, 5, 20, 700);
    rom[2] = entry(1'b1, 1, 9, 64, 1712);
    run_song("rest_dur0", 1'b0, 10, 1'b0);

    // Random tables; the first one also pokes start while busy.
    for (int trial = 0; trial < 6; trial++) begin
      int n;
      n = (trial == 0) ? 5 : int'($urandom_range(1, 6));
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      for (int i = 0; i < n; i++)
        rom[i] = (trial == 0) ? entry(i == n - 1, $urandom_range(1, 3), $urandom_range(0, 31),
                                      $urandom_range(0, 127), $urandom_range(1, 2047))
                              : rand_entry(i == n - 1, 3);
      run_song("random", 1'b0, 10, trial == 0);
    end

    // Full table without an end flag stops at the last address.
    for (int i = 0; i < 256; i++) rom[i] = rand_entry(1'b0, 0);
    run_song("full_table", 1'b0, 300, 1'b0);

    // Asynchronous reset in the middle of a note, then a fresh start.
    rom[0] = entry(1'b0, 3, 8, 50, 1358);
    rom[1] = entry(1'b0, 3, 8, 50, 1524);
    rom[2] = entry(1'b1, 2, 8, 50, 1712);
    exp_q.delete();
    exp_q.push_back('{0, rom[0]});
    mon_en = 1'b1;
    pulse_ctl(1'b1, 1'b0);
    wait_t = 0;
    while (wait_t < 200 && !playing) begin
      @(negedge clk);
      wait_t++;
    end
    check_eq("reach_play", playing, 1);
    mon_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_reg1", bus.reg1, 8'h80);
    check_eq("async_busy", bus.busy, 0);
    check_eq("async_reg2", bus.reg2, 8'h00);
    check_eq("async_addr", bus.rom_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    run_song("after_reset", 1'b0, 10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
